// File: rtl/rom_sequencer.sv
// ROM-driven instruction sequencer: fetches 20-bit words, issues operands
// via valid/ready, supports single-step, halt and a manual (disabled) mode.
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   enable                 1 = run from ROM, 0 = manual mode (IDLE)
//   step_mode, step        single-step select and advance pulse
//   rom_addr, rom_data     ROM address out, word back one cycle later
//                          rom_data = {halt, opcode[2:0], a[7:0], b[7:0]}
//   cpu_a/b/opcode/valid   instruction to the operand mux
//   cpu_ready              consumer accepts the instruction this cycle
//   halted, pc             HALT status, current instruction address
//   instr_count            saturating count of accepted instructions
module rom_sequencer #(
  parameter int          PC_W      = 4,
  parameter int unsigned LAST_ADDR = (1 << PC_W) - 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            step_mode,
  input  logic            step,
  output logic [PC_W-1:0] rom_addr,
  input  logic [19:0]     rom_data,
  output logic [7:0]      cpu_a,
  output logic [7:0]      cpu_b,
  output logic [2:0]      cpu_opcode,
  output logic            cpu_valid,
  input  logic            cpu_ready,
  output logic            halted,
  output logic [PC_W-1:0] pc,
  output logic [7:0]      instr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_STEPWAIT,
    S_HALT
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      a_q, a_d;
  logic [7:0]      b_q, b_d;
  logic [2:0]      op_q, op_d;
  logic            accept;

  assign accept = (state_q == S_ISSUE) && cpu_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;

    // Acceptance counts even if enable drops in the same cycle.
    if (accept) begin
      pc_d  = (pc_q == PC_W'(LAST_ADDR)) ? '0 : pc_q + 1'b1;
      cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (rom_data[19]) begin
          state_d = S_HALT;
        end else begin
          state_d = S_ISSUE;
          if (enable) begin
            a_d  = rom_data[15:8];
            b_d  = rom_data[7:0];
            op_d = rom_data[18:16];
          end
        end
      end
      S_ISSUE: begin
        if (cpu_ready) begin
          state_d = step_mode ? S_STEPWAIT : S_FETCH;
        end
      end
      S_STEPWAIT: begin
        if (step) state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Dropping enable abandons any unaccepted word; pc is kept so the
    // same address is re-fetched on re-enable.
    if (!enable) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
    end
  end

  assign rom_addr    = pc_q;
  assign pc          = pc_q;
  assign instr_count = cnt_q;
  assign cpu_a       = a_q;
  assign cpu_b       = b_q;
  assign cpu_opcode  = op_q;
  assign cpu_valid   = (state_q == S_ISSUE);
  assign halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_rom_sequencer.sv
// Testbench for rom_sequencer: per-cycle vector table plus directed
// sequences for free-run/halt, reset-in-HALT and pc wrap/saturation.
module tb_rom_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance, PC_W = 4
  logic        rst, en, sm, stp, rdy;
  logic [3:0]  rom_addr, pc;
  logic [19:0] rom_data;
  logic [7:0]  a, b, cnt;
  logic [2:0]  op;
  logic        vld, hlt;
  logic [19:0] rom [16];

  // Wrap instance, PC_W = 2
  logic        rst2, en2, rdy2;
  logic [1:0]  rom_addr2, pc2;
  logic [19:0] rom_data2;
  logic [7:0]  a2, b2, cnt2;
  logic [2:0]  op2;
  logic        vld2, hlt2;
  logic [19:0] rom2 [4];

  int checks = 0;
  int failures = 0;

  rom_sequencer #(.PC_W(4)) dut (
    .clk(clk), .reset(rst), .enable(en), .step_mode(sm), .step(stp),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .cpu_a(a), .cpu_b(b), .cpu_opcode(op), .cpu_valid(vld),
    .cpu_ready(rdy), .halted(hlt), .pc(pc), .instr_count(cnt)
  );

  rom_sequencer #(.PC_W(2)) dut2 (
    .clk(clk), .reset(rst2), .enable(en2), .step_mode(1'b0),
    .step(1'b0), .rom_addr(rom_addr2), .rom_data(rom_data2),
    .cpu_a(a2), .cpu_b(b2), .cpu_opcode(op2), .cpu_valid(vld2),
    .cpu_ready(rdy2), .halted(hlt2), .pc(pc2), .instr_count(cnt2)
  );

  // Synchronous ROMs: data valid one cycle after the address.
  always @(posedge clk) rom_data  <= rom[rom_addr];
  always @(posedge clk) rom_data2 <= rom2[rom_addr2];

  typedef struct {
    logic       rst, en, sm, stp, rdy;
    logic       vld, hlt;
    logic [3:0] pc;
    logic [7:0] cnt, a, b;
    logic [2:0] op;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic r, logic e, logic s, logic st,
                              logic rd, logic v, logic h, logic [3:0] p,
                              logic [7:0] c, logic [7:0] xa,
                              logic [7:0] xb, logic [2:0] xo);
    vec_t t;
    t.rst = r; t.en = e; t.sm = s; t.stp = st; t.rdy = rd;
    t.vld = v; t.hlt = h; t.pc = p; t.cnt = c;
    t.a = xa; t.b = xb; t.op = xo;
    return t;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] seen_pc [$];
  int         n_acc;
  int         budget;

  initial begin
    rst = 1; en = 0; sm = 0; stp = 0; rdy = 0;
    rst2 = 1; en2 = 0; rdy2 = 0;
    rom[0] = {1'b0, 3'd1, 8'h05, 8'h03};
    rom[1] = {1'b0, 3'd2, 8'h11, 8'h22};
    rom[2] = {1'b0, 3'd3, 8'h33, 8'h44};
    rom[3] = {1'b1, 3'd7, 8'hEE, 8'hDD};
    for (int i = 4; i < 16; i++) rom[i] = {1'b1, 19'h0};
    for (int i = 0; i < 4; i++) rom2[i] = {1'b0, 3'(i), 8'(i), 8'(i)};

    // Fields: rst en sm stp rdy | vld hlt pc cnt a b op
    vt.push_back(mk(0,1,0,0,1, 0,0,0,0,8'h00,8'h00,0));
    vt.push_back(mk(0,1,0,0,1, 0,0,0,0,8'h00,8'h00,0));
    vt.push_back(mk(0,1,0,0,1, 1,0,0,0,8'h05,8'h03,1));
    for (int i = 0; i < 5; i++)
      vt.push_back(mk(0,1,0,0,0, 1,0,0,0,8'h05,8'h03,1));
    vt.push_back(mk(0,1,0,0,1, 0,0,1,1,8'h05,8'h03,1));
    vt.push_back(mk(0,1,0,0,1, 0,0,1,1,8'h05,8'h03,1));
    vt.push_back(mk(0,1,0,0,1, 1,0,1,1,8'h11,8'h22,2));
    vt.push_back(mk(0,1,0,0,1, 0,0,2,2,8'h11,8'h22,2));
    vt.push_back(mk(0,1,0,0,1, 0,0,2,2,8'h11,8'h22,2));
    vt.push_back(mk(0,1,0,0,0, 1,0,2,2,8'h33,8'h44,3));
    vt.push_back(mk(0,0,0,0,0, 0,0,2,2,8'h33,8'h44,3));
    vt.push_back(mk(0,0,0,0,0, 0,0,2,2,8'h33,8'h44,3));
    vt.push_back(mk(0,1,0,0,0, 0,0,2,2,8'h33,8'h44,3));
    vt.push_back(mk(0,1,0,0,0, 0,0,2,2,8'h33,8'h44,3));
    vt.push_back(mk(0,1,0,0,0, 1,0,2,2,8'h33,8'h44,3));
    vt.push_back(mk(0,0,0,0,1, 0,0,3,3,8'h33,8'h44,3));
    vt.push_back(mk(0,1,0,0,1, 0,0,3,3,8'h33,8'h44,3));
    vt.push_back(mk(0,1,0,0,1, 0,0,3,3,8'h33,8'h44,3));
    vt.push_back(mk(0,1,0,0,1, 0,1,3,3,8'h33,8'h44,3));
    vt.push_back(mk(0,1,0,0,1, 0,1,3,3,8'h33,8'h44,3));
    vt.push_back(mk(0,0,0,0,1, 0,0,3,3,8'h33,8'h44,3));
    vt.push_back(mk(1,1,0,0,1, 0,0,0,0,8'h00,8'h00,0));
    vt.push_back(mk(0,1,1,0,1, 0,0,0,0,8'h00,8'h00,0));
    vt.push_back(mk(0,1,1,0,1, 0,0,0,0,8'h00,8'h00,0));
    vt.push_back(mk(0,1,1,1,1, 1,0,0,0,8'h05,8'h03,1));
    vt.push_back(mk(0,1,1,1,0, 1,0,0,0,8'h05,8'h03,1));
    vt.push_back(mk(0,1,1,0,1, 0,0,1,1,8'h05,8'h03,1));
    vt.push_back(mk(0,1,1,0,1, 0,0,1,1,8'h05,8'h03,1));
    vt.push_back(mk(0,1,1,0,1, 0,0,1,1,8'h05,8'h03,1));
    vt.push_back(mk(0,1,1,1,1, 0,0,1,1,8'h05,8'h03,1));
    vt.push_back(mk(0,1,1,0,1, 0,0,1,1,8'h05,8'h03,1));
    vt.push_back(mk(0,1,1,0,1, 1,0,1,1,8'h11,8'h22,2));
    vt.push_back(mk(1,1,1,0,1, 0,0,0,0,8'h00,8'h00,0));

    // Reset state, with enable high to show reset wins.
    en = 1;
    tick();
    tick();
    check("reset_state",
          {rom_addr, pc, cnt, a, b, op, vld, hlt},
          {4'd0, 4'd0, 8'd0, 8'd0, 8'd0, 3'd0, 1'b0, 1'b0});

    for (int i = 0; i < vt.size(); i++) begin
      rst = vt[i].rst; en = vt[i].en; sm = vt[i].sm;
      stp = vt[i].stp; rdy = vt[i].rdy;
      tick();
      check($sformatf("vec%0d", i),
            {vld, hlt, pc, cnt, a, b, op, rom_addr},
            {vt[i].vld, vt[i].hlt, vt[i].pc, vt[i].cnt,
             vt[i].a, vt[i].b, vt[i].op, vt[i].pc});
    end

    // Free-run into a halt word at address 1.
    rom[1] = {1'b1, 19'h0};
    rst = 0; en = 1; sm = 0; stp = 0; rdy = 1;
    tick();
    check("fr_c1_valid", 64'(vld), 64'd0);
    tick();
    check("fr_c2_valid", 64'(vld), 64'd0);
    tick();
    check("fr_c3_issue", {vld, a, b, op}, {1'b1, 8'h05, 8'h03, 3'd1});
    tick();
    tick();
    tick();
    check("fr_halt", {hlt, vld, pc, cnt}, {1'b1, 1'b0, 4'd1, 8'd1});
    tick();
    tick();
    check("fr_halt_hold", {hlt, vld, pc, cnt}, {1'b1, 1'b0, 4'd1, 8'd1});

    // Reset while halted, then a fresh run from pc 0.
    rst = 1;
    tick();
    check("rst_in_halt",
          {rom_addr, pc, cnt, a, b, op, vld, hlt},
          {4'd0, 4'd0, 8'd0, 8'd0, 8'd0, 3'd0, 1'b0, 1'b0});
    rst = 0;
    tick();
    tick();
    tick();
    check("fresh_run", {vld, pc, a, b, op},
          {1'b1, 4'd0, 8'h05, 8'h03, 3'd1});

    // Wrap and saturation on the 2-bit instance.
    rst2 = 1; en2 = 1; rdy2 = 1;
    tick();
    rst2 = 0;
    n_acc = 0;
    budget = 2000;
    while (n_acc < 300 && budget > 0) begin
      tick();
      budget--;
      if (vld2) begin
        if (n_acc < 5) seen_pc.push_back({2'b00, pc2});
        n_acc++;
        if (n_acc == 200) check("cnt_at_200", 64'(cnt2), 64'd199);
      end
    end
    check("wrap_budget", 64'(n_acc), 64'd300);
    check("wrap_seq",
          {seen_pc[0], seen_pc[1], seen_pc[2], seen_pc[3], seen_pc[4]},
          {4'd0, 4'd1, 4'd2, 4'd3, 4'd0});
    tick();
    check("cnt_saturate", 64'(cnt2), 64'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
